// File: rtl/pixel_op_sequencer.sv
// Pixel operation sequencer: walks an image buffer one 32-bit word at a time,
// reads each word from data memory, presents it to the SIMD lanes until they
// accept it, and drives the per-lane pixel/immediate selects for the job.
module pixel_op_sequencer #(
    parameter int ADDR_W = 16,
    parameter int LEN_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [LEN_W-1:0]  num_words,
    input  logic [3:0]        imm_mask,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [31:0]       mem_rd_data,
    output logic [31:0]       pixel_word,
    output logic [3:0]        select_pixel,
    output logic              op_valid,
    input  logic              op_ready,
    output logic              busy,
    output logic              done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_WAIT,
        S_ISSUE,
        S_DONE
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] addr_q;      // address of the next word to read
    logic [LEN_W-1:0]  remain_q;    // words still to be read after the current one
    logic [3:0]        mask_q;      // job-constant immediate mask
    logic [ADDR_W-1:0] mem_addr_q;  // holds the last issued read address
    logic [31:0]       pixel_q;     // operand held for the lanes

    // Abort only matters once a job is running; in IDLE it just masks start.
    logic abort_job;
    logic accept_start;
    assign abort_job    = abort && (state != S_IDLE);
    assign accept_start = (state == S_IDLE) && start && !abort;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic; abort overrides everything including a handshake.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (accept_start)
                    state_nxt = (num_words == '0) ? S_DONE : S_READ;
            end
            S_READ:  state_nxt = S_WAIT;
            S_WAIT:  state_nxt = S_ISSUE;
            S_ISSUE: begin
                if (op_ready)
                    state_nxt = (remain_q == '0) ? S_DONE : S_READ;
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
        if (abort_job) state_nxt = S_IDLE;
    end

    // Moore outputs decoded from the current state.
    always_comb begin
        mem_rd_en    = (state == S_READ);
        op_valid     = (state == S_ISSUE);
        busy         = (state != S_IDLE);
        done         = (state == S_DONE);
        select_pixel = 4'h0;
        if (state == S_READ || state == S_WAIT || state == S_ISSUE)
            select_pixel = mask_q;
    end

    assign mem_addr   = mem_addr_q;
    assign pixel_word = pixel_q;

    // Job context: address/length/mask latch at start, address and count
    // step once per word when the read data is captured.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q   <= '0;
            remain_q <= '0;
            mask_q   <= 4'h0;
        end else if (accept_start) begin
            addr_q   <= base_addr;
            remain_q <= num_words;
            mask_q   <= imm_mask;
        end else if (state == S_WAIT && !abort_job) begin
            addr_q   <= addr_q + ADDR_W'(1);
            remain_q <= remain_q - LEN_W'(1);
        end
    end

    // Read address and operand registers; an abort drops the in-flight beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_addr_q <= '0;
            pixel_q    <= '0;
        end else if (abort_job) begin
            mem_addr_q <= '0;
            pixel_q    <= '0;
        end else begin
            // The first read of a job uses base_addr directly since addr_q
            // is being loaded on the same edge.
            if (state_nxt == S_READ)
                mem_addr_q <= (state == S_IDLE) ? base_addr : addr_q;
            if (state == S_WAIT)
                pixel_q <= mem_rd_data;
        end
    end

endmodule

// File: doc/pixel_op_sequencer.md
Name: pixel_op_sequencer

Overview:
- Sequences one vector pixel operation across an image buffer: fetches 32-bit words (4 packed 8-bit pixels), holds each on the operand bus until the SIMD datapath accepts it, and drives per-lane pixel/immediate select lines to the four lane muxes.
- Sits between the decode/control unit (start, base, length, lane mask) and the data memory read port plus the lane datapath.

Parameters:
- ADDR_W, 16, word address width of data memory.
- LEN_W, 16, width of the word-count field.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  one-cycle job request; sampled only in IDLE.
- abort  input  1  synchronous job cancel.
- base_addr  input  ADDR_W  first word address of the job.
- num_words  input  LEN_W  number of 32-bit words to process.
- imm_mask  input  4  bit i = 1 makes lane i take the immediate instead of the pixel.
- mem_rd_en  output  1  memory read strobe.
- mem_addr  output  ADDR_W  memory read address.
- mem_rd_data  input  32  read data, valid exactly 1 cycle after mem_rd_en.
- pixel_word  output  32  operand word to lanes; pixel i = bits [8i+7:8i].
- select_pixel  output  4  lane mux selects; bit i drives lane i.
- op_valid  output  1  pixel_word is valid.
- op_ready  input  1  datapath accepts when op_valid and op_ready are both high.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse at normal job completion.

Behaviour:
- Reset (rst_n low, asynchronous): state IDLE.
  - All outputs 0: mem_rd_en, mem_addr, pixel_word, select_pixel, op_valid, busy, done.
  - Internal counters and latched mask cleared.
- States: IDLE, READ, WAIT, ISSUE, DONE.
- IDLE:
  - On start=1, latch base_addr into the address counter, num_words into the remaining counter, and imm_mask into the mask register.
  - If num_words=0, go to DONE; otherwise go to READ.
  - start is ignored in every other state.
- READ: assert mem_rd_en=1 for exactly one cycle with mem_addr = current address; go to WAIT.
- WAIT:
  - Capture mem_rd_data into pixel_word.
  - Increment the address modulo 2^ADDR_W, so ADDR_W'hFFFF wraps to 0.
  - Decrement the remaining counter; go to ISSUE.
- ISSUE:
  - op_valid=1; pixel_word is held stable until the handshake completes.
  - On op_valid & op_ready: if remaining=0, go to DONE, else go to READ.
  - op_valid drops the cycle after the handshake.
- DONE: done=1 for one cycle, busy=1; then IDLE.
- select_pixel equals the latched mask in READ, WAIT and ISSUE; it is 0 in IDLE and DONE.
  - The mask is constant for the whole job; changes to imm_mask mid-job have no effect.
- mem_addr holds its last value when mem_rd_en=0.
- Throughput: minimum 3 cycles per word (READ, WAIT, ISSUE with op_ready=1). Every op_ready-low cycle in ISSUE adds one cycle.
- abort=1 in any non-IDLE state:
  - Next state is IDLE, with op_valid, mem_rd_en and select_pixel cleared.
  - No done pulse. A read data beat still returning is discarded.
  - abort has priority over the handshake in the same cycle: that word counts as not transferred.
  - abort in IDLE: no effect, and it blocks a simultaneous start.
- Reset mid-job: immediate return to the reset values; no done.
- num_words is an unsigned count; the maximum 2^LEN_W-1 must complete without counter overflow.

Test Plan:
- Basic job: base=0x0010, num_words=2, mask=4'b0000; memory returns 0x44332211 then 0x88776655; op_ready=1.
  - Required: reads at 0x0010 and 0x0011.
  - Two op_valid handshakes carrying those words.
  - done pulses 7 cycles after start; busy low afterwards.
- Backpressure: same job with op_ready=0 for 5 cycles on the first word.
  - Required: pixel_word holds 0x44332211 with op_valid=1 throughout the stall.
  - No second read until the handshake.
  - done is delayed by exactly 5 cycles.
- Mask latch: start with mask=4'b1010, change imm_mask to 4'b0101 mid-job.
  - Required: select_pixel=4'b1010 from READ through the final ISSUE.
  - select_pixel=0 in DONE.
- Zero length: start with num_words=0.
  - Required: no mem_rd_en; done high on cycle start+1; back to IDLE on start+2.
- Wrap and abort:
  - base=0xFFFF, num_words=3: reads at 0xFFFF, 0x0000, 0x0001.
  - Assert abort during the second ISSUE together with op_ready=1: IDLE next cycle, no done, outputs 0.
- Async reset: drop rst_n mid-WAIT between clock edges.
  - Required: all outputs 0 immediately, before the next edge.
  - After release, the next start runs normally.
